// File: rtl/weight_feed_if.sv
// weight_feed_if: bundles the sequencer controls, the synchronous weight
// memory read port and the weight delivery port of weight_feed_ctrl.
//
// Handshake semantics: there is no backpressure anywhere. start_weights and
// start_layering are single-cycle kicks qualified by mode. mem_rdata is
// expected the cycle after a mem_rd_en cycle. w_valid marks a word that the
// array must take in that same cycle. w_latch, load_done and err are
// single-cycle pulses. weights_ready and busy are levels.
//
// Modports:
//   slave  - the controller side (weight_feed_ctrl)
//   master - the sequencer/memory/array side (environment)
interface weight_feed_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ROW_W  = 2
);
  logic [2:0]        mode;
  logic              start_weights;
  logic              start_layering;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic [ROW_W-1:0]  w_row;
  logic              w_latch;
  logic              load_done;
  logic              weights_ready;
  logic              busy;
  logic              err;

  modport slave (
    input  mode, start_weights, start_layering, base_addr, mem_rdata,
    output mem_rd_en, mem_addr, w_valid, w_data, w_row, w_latch,
           load_done, weights_ready, busy, err
  );

  modport master (
    output mode, start_weights, start_layering, base_addr, mem_rdata,
    input  mem_rd_en, mem_addr, w_valid, w_data, w_row, w_latch,
           load_done, weights_ready, busy, err
  );
endinterface

// File: rtl/weight_feed_ctrl.sv
// weight_feed_ctrl: fetches ROWS consecutive weight words from a synchronous
// memory starting at base_addr, forwards each to the array tagged with its
// row, then waits in READY until a layer kick commits them with w_latch.
//
// Ports:
//   clk, rst   - single rising-edge clock, asynchronous active-high reset
//   bus        - weight_feed_if.slave (controls, memory port, array port)
//   dbg_state  - current FSM state encoding, for observation only
//
// Every output is a flop. Word path: mem_rd_en cycle -> memory returns data
// next cycle -> data captured into w_data, visible two cycles after the read.
module weight_feed_ctrl #(
  parameter int ROWS   = 4,
  parameter int ROW_W  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  weight_feed_if.slave     bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_READY = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rd_d1_q, rd_d1_d;
  logic [ROW_W-1:0]  row_d1_q, row_d1_d;
  logic              w_valid_q, w_valid_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [ROW_W-1:0]  w_row_q, w_row_d;
  logic              w_latch_q, w_latch_d;
  logic              load_done_q, load_done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic sw, sl;

  always_comb begin
    sw = bus.start_weights && (bus.mode == 3'd1);
    // A layer kick arriving together with a load kick in READY rides along
    // with the load (mode is LOAD then), so it counts as a layer request.
    sl = bus.start_layering &&
         ((bus.mode == 3'd2) ||
          ((state_q == S_READY) && bus.start_weights && (bus.mode == 3'd1)));

    state_d     = state_q;
    pending_d   = pending_q;
    row_d       = row_q;
    addr_d      = addr_q;
    rd_en_d     = 1'b0;
    err_d       = 1'b0;
    load_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        err_d = sl;
        if (sw) begin
          state_d = S_FETCH;
          row_d   = '0;
          addr_d  = bus.base_addr;
          rd_en_d = 1'b1;
        end
      end
      S_FETCH: begin
        err_d = sw || (sl && pending_q);
        if (sl) pending_d = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = S_DRAIN;
        end else begin
          row_d   = row_q + ROW_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        err_d = sw || (sl && pending_q);
        if (sl) pending_d = 1'b1;
        // Leave once the final row is on w_valid this cycle.
        if (w_valid_q && (w_row_q == LAST_ROW)) begin
          state_d     = S_READY;
          load_done_d = 1'b1;
        end
      end
      S_READY: begin
        err_d = sl && pending_q;
        if (sw) begin
          state_d = S_FETCH;
          row_d   = '0;
          addr_d  = bus.base_addr;
          rd_en_d = 1'b1;
          if (sl) pending_d = 1'b1;
        end else if (sl || pending_q) begin
          state_d   = S_LATCH;
          pending_d = 1'b0;
        end
      end
      S_LATCH: begin
        err_d   = sw || sl;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mem_addr_d = rd_en_d ? addr_d : '0;

    // Two-stage word pipeline: stage 1 tracks the read issued last cycle,
    // stage 2 captures the memory data that read returned.
    rd_d1_d   = rd_en_q;
    row_d1_d  = rd_en_q ? row_q : '0;
    w_valid_d = rd_d1_q;
    w_data_d  = rd_d1_q ? bus.mem_rdata : '0;
    w_row_d   = rd_d1_q ? row_d1_q : '0;

    w_latch_d = (state_d == S_LATCH);
    ready_d   = (state_d == S_READY);
    busy_d    = (state_d == S_FETCH) || (state_d == S_DRAIN) ||
                (state_d == S_LATCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      row_q       <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      mem_addr_q  <= '0;
      rd_d1_q     <= 1'b0;
      row_d1_q    <= '0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      w_row_q     <= '0;
      w_latch_q   <= 1'b0;
      load_done_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rd_d1_q     <= rd_d1_d;
      row_d1_q    <= row_d1_d;
      w_valid_q   <= w_valid_d;
      w_data_q    <= w_data_d;
      w_row_q     <= w_row_d;
      w_latch_q   <= w_latch_d;
      load_done_q <= load_done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_rd_en     = rd_en_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.w_valid       = w_valid_q;
  assign bus.w_data        = w_data_q;
  assign bus.w_row         = w_row_q;
  assign bus.w_latch       = w_latch_q;
  assign bus.load_done     = load_done_q;
  assign bus.weights_ready = ready_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_weight_feed_ctrl.sv
module tb_weight_feed_ctrl;
  localparam int ROWS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         t        = 0;

  weight_feed_if #(.ADDR_W(8), .DATA_W(8), .ROW_W(2)) bus ();

  weight_feed_ctrl #(.ROWS(ROWS), .ROW_W(2), .ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [7:0] mem_val(input logic [7:0] a);
    return 8'(a * 8'd3 + 8'd7);
  endfunction

  always @(posedge clk)
    bus.mem_rdata <= bus.mem_rd_en ? mem_val(bus.mem_addr) : 8'hEE;

  // ---------------- checker ----------------
  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @t=%0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the load as an age (cycles since acceptance); the outputs are
  // functions of that age: reads at ages 1..ROWS, words at ages 3..ROWS+2.
  typedef enum int {M_IDLE, M_LOAD, M_READY, M_LATCH} mphase_t;
  mphase_t    ph = M_IDLE;
  int         age = 0;
  logic [7:0] mbase = 8'h00;
  bit         mpend = 1'b0;
  bit         m_ld = 1'b0, m_err = 1'b0;

  logic       e_rd, e_wv, e_latch, e_ld, e_rdy, e_busy, e_err;
  logic [7:0] e_addr, e_wd;
  logic [1:0] e_row;

  task automatic derive();
    e_rd    = (ph == M_LOAD) && (age <= ROWS);
    e_addr  = e_rd ? 8'(mbase + 8'(age - 1)) : 8'h00;
    e_wv    = (ph == M_LOAD) && (age >= 3) && (age <= ROWS + 2);
    e_row   = e_wv ? 2'(age - 3) : 2'd0;
    e_wd    = e_wv ? mem_val(8'(mbase + 8'(age - 3))) : 8'h00;
    e_latch = (ph == M_LATCH);
    e_rdy   = (ph == M_READY);
    e_busy  = (ph == M_LOAD) || (ph == M_LATCH);
    e_ld    = m_ld;
    e_err   = m_err;
  endtask

  task automatic model_step();
    bit sw, sl;
    sw = bus.start_weights && (bus.mode == 3'd1);
    sl = bus.start_layering && (bus.mode == 3'd2);
    if (ph == M_READY && bus.start_weights && bus.start_layering && bus.mode == 3'd1)
      sl = 1'b1;
    m_ld  = 1'b0;
    m_err = 1'b0;
    case (ph)
      M_IDLE: begin
        if (sl) m_err = 1'b1;
        if (sw) begin ph = M_LOAD; age = 1; mbase = bus.base_addr; end
      end
      M_LOAD: begin
        if (sw) m_err = 1'b1;
        if (sl) begin if (mpend) m_err = 1'b1; else mpend = 1'b1; end
        if (age == ROWS + 2) begin ph = M_READY; m_ld = 1'b1; end
        else age++;
      end
      M_READY: begin
        if (sl && mpend) m_err = 1'b1;
        if (sw) begin
          if (sl) mpend = 1'b1;
          ph = M_LOAD; age = 1; mbase = bus.base_addr;
        end else if (sl || mpend) begin
          ph = M_LATCH; mpend = 1'b0;
        end
      end
      default: begin
        if (sw || sl) m_err = 1'b1;
        ph = M_IDLE;
      end
    endcase
  endtask

  // Compare process: every negedge, DUT outputs vs model expectations.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      ph = M_IDLE; mpend = 1'b0; m_ld = 1'b0; m_err = 1'b0;
      derive();
    end
    check("mem_rd_en",     bus.mem_rd_en,     e_rd);
    check("mem_addr",      bus.mem_addr,      e_addr);
    check("w_valid",       bus.w_valid,       e_wv);
    check("w_data",        bus.w_data,        e_wd);
    check("w_row",         bus.w_row,         e_row);
    check("w_latch",       bus.w_latch,       e_latch);
    check("load_done",     bus.load_done,     e_ld);
    check("weights_ready", bus.weights_ready, e_rdy);
    check("busy",          bus.busy,          e_busy);
    check("err",           bus.err,           e_err);
    if (rst !== 1'b1) model_step();
    derive();
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic go(input int k);
    while (t < k) next_cycle();
  endtask

  task automatic start_test();
    next_cycle();
    t = 0;
  endtask

  task automatic drive(input logic [2:0] m, input logic w, input logic l,
                       input logic [7:0] b);
    bus.mode = m; bus.start_weights = w; bus.start_layering = l; bus.base_addr = b;
  endtask

  task automatic idle_in();
    drive(3'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_in();
    bus.mem_rdata = 8'h00;
    repeat (3) next_cycle();
    rst = 1'b0;
    at_neg();
    check("reset_busy", bus.busy, 1'b0);
    check("reset_ready", bus.weights_ready, 1'b0);

    // Basic load at 0x10 with layer kick during FETCH.
    start_test();
    drive(3'd1, 1'b1, 1'b0, 8'h10);
    go(1); drive(3'd2, 1'b0, 1'b1, 8'h00);
    at_neg(); check("t1_rd_en_c1", bus.mem_rd_en, 1'b1);
    check("t1_addr_c1", bus.mem_addr, 8'h10);
    go(2); idle_in();
    at_neg(); check("t1_no_err_c2", bus.err, 1'b0);
    go(3); at_neg(); check("t1_wv_c3", bus.w_valid, 1'b1);
    check("t1_row_c3", bus.w_row, 2'd0);
    check("t1_wdata_c3", bus.w_data, 8'h37);
    go(4); at_neg(); check("t1_addr_c4", bus.mem_addr, 8'h13);
    go(6); at_neg(); check("t1_row_c6", bus.w_row, 2'd3);
    go(7); at_neg(); check("t1_load_done_c7", bus.load_done, 1'b1);
    check("t1_ready_c7", bus.weights_ready, 1'b1);
    go(8); at_neg(); check("t1_latch_c8", bus.w_latch, 1'b1);
    go(9); at_neg(); check("t1_busy_c9", bus.busy, 1'b0);

    // Address wrap at 0xFE.
    start_test();
    drive(3'd1, 1'b1, 1'b0, 8'hFE);
    go(1); idle_in();
    at_neg(); check("t2_addr0", bus.mem_addr, 8'hFE);
    go(2); at_neg(); check("t2_addr1", bus.mem_addr, 8'hFF);
    go(3); at_neg(); check("t2_addr2", bus.mem_addr, 8'h00);
    go(4); at_neg(); check("t2_addr3", bus.mem_addr, 8'h01);
    go(8); drive(3'd2, 1'b0, 1'b1, 8'h00);
    go(9); idle_in();
    go(10);

    // Protocol errors and silent ignores.
    start_test();
    drive(3'd2, 1'b0, 1'b1, 8'h00);
    go(1); drive(3'd2, 1'b1, 1'b0, 8'h99);
    at_neg(); check("t3_err_idle_layer", bus.err, 1'b1);
    check("t3_no_latch", bus.w_latch, 1'b0);
    go(2); idle_in();
    at_neg(); check("t3_silent_err", bus.err, 1'b0);
    check("t3_silent_rd", bus.mem_rd_en, 1'b0);
    go(3); drive(3'd1, 1'b1, 1'b0, 8'h40);
    go(4); idle_in();
    go(5); drive(3'd1, 1'b1, 1'b0, 8'h80);
    go(6); idle_in();
    at_neg(); check("t3_err_fetch", bus.err, 1'b1);
    check("t3_addr_c6", bus.mem_addr, 8'h42);
    go(7); at_neg(); check("t3_addr_c7", bus.mem_addr, 8'h43);
    go(10); drive(3'd2, 1'b0, 1'b1, 8'h00);
    go(11); idle_in();
    go(12);

    // Reset in mid-FETCH with a pending layer kick, then reload.
    start_test();
    drive(3'd1, 1'b1, 1'b0, 8'h20);
    go(1); drive(3'd2, 1'b0, 1'b1, 8'h00);
    go(2); idle_in();
    go(3); rst = 1'b1;
    at_neg(); check("t4_rst_busy", bus.busy, 1'b0);
    check("t4_rst_rd", bus.mem_rd_en, 1'b0);
    go(4); rst = 1'b0; drive(3'd1, 1'b1, 1'b0, 8'h30);
    at_neg(); check("t4_rst_wv", bus.w_valid, 1'b0);
    go(5); idle_in();
    at_neg(); check("t4_rd_c5", bus.mem_rd_en, 1'b1);
    check("t4_addr_c5", bus.mem_addr, 8'h30);
    go(11); at_neg(); check("t4_load_done", bus.load_done, 1'b1);
    go(12); at_neg(); check("t4_no_stale_latch", bus.w_latch, 1'b0);
    check("t4_still_ready", bus.weights_ready, 1'b1);

    // Load and layer kicks together in READY.
    drive(3'd1, 1'b1, 1'b1, 8'h50);
    go(13); idle_in();
    at_neg(); check("t5_rd", bus.mem_rd_en, 1'b1);
    check("t5_addr", bus.mem_addr, 8'h50);
    check("t5_no_err", bus.err, 1'b0);
    go(19); at_neg(); check("t5_load_done", bus.load_done, 1'b1);
    go(20); at_neg(); check("t5_latch", bus.w_latch, 1'b1);
    go(21); at_neg(); check("t5_latch_once", bus.w_latch, 1'b0);
    check("t5_idle_busy", bus.busy, 1'b0);

    go(23);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
